wb_mem_bank_scheduler: RTL and testbench
========================================

// Module: wb_mem_bank_scheduler
// PURPOSE
//  Sequences two host-filled memory banks into the memory-to-PPFIFO reader in strict commit order.
//  Host commits (base,size) buffers; block owns both bank slots, releases one bank at a time, detects drain, frees it.
//  Sits between the host control registers and the reader's memory_0/1 base/size/new_data/count/read_finished ports.
// PARAMETERS
//  BANK_SIZE_MAX   32'h00200000  largest legal commit size in words; larger commits are rejected
//  TIMEOUT_CYCLES  65536         drain watchdog limit; used only with WB_MEM_SCHED_TIMEOUT_EN
// PORTS
//  clk               in   1   single clock
//  rst               in   1   asynchronous, active-high reset
//  i_enable          in   1   allow new bank releases
//  i_flush           in   1   pulse: drop all banks to FREE
//  i_commit          in   1   pulse: commit buffer described by i_commit_base/size
//  i_commit_base     in   32  word base address of committed buffer
//  i_commit_size     in   32  word count of committed buffer
//  o_commit_ready    out  1   at least one bank FREE
//  o_commit_err      out  1   pulse: commit rejected (no FREE bank or size>BANK_SIZE_MAX)
//  o_mem_0_base      out  32  bank 0 base to reader
//  o_mem_0_size      out  32  bank 0 size; 0 unless bank 0 is DRAINING
//  o_mem_0_new_data  out  1   pulse: reader resets bank 0 pointer
//  i_mem_0_count     in   32  reader's remaining count, bank 0
//  o_mem_1_base, o_mem_1_size, o_mem_1_new_data, i_mem_1_count: same for bank 1
//  i_read_finished   in   1   reader pulse: a block was consumed
//  o_done            out  1   pulse: a bank finished draining
//  o_done_bank       out  1   bank index of last o_done (holds)
//  o_irq             out  1   level; set with o_done, cleared by i_irq_clear (clear wins on same cycle)
//  i_irq_clear       in   1   pulse
//  o_busy            out  1   any bank LOADED or DRAINING
//  o_timeout         out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset: all banks FREE; all outputs 0 except o_commit_ready=1; o_mem_N_base = 0.
//  Per-bank state: FREE -> LOADED (commit) -> DRAINING (release) -> FREE (drain or flush).
//  Commit: bank 0 preferred when both FREE; base/size registered in the cycle after i_commit.
//    Bank is LOADED and its index is pushed to a 2-entry order queue.
//    Only banks FREE at the start of the cycle are eligible; a bank freed in the same cycle is not.
//  Zero-size commit: accepted, bank stays FREE; o_done pulses next cycle, no release.
//  Release conditions: i_enable=1, no bank DRAINING, queue head LOADED.
//    Bank -> DRAINING; o_mem_N_size=size and o_mem_N_new_data=1 for 1 cycle, same edge.
//    Release latency: 1 cycle after conditions are met; queue pops.
//    Non-DRAINING banks present size 0; reader sees count 0 and ignores them.
//  Drain detect: DRAINING bank N, i_read_finished=1, i_mem_N_count==0.
//    Next edge: bank FREE, o_mem_N_size=0, o_done=1, o_done_bank=N, o_irq=1.
//    i_read_finished with count!=0 is ignored.
//  Commit and drain on the same cycle: both take effect. Back-to-back release of the other bank waits 1 cycle.
//  i_enable low mid-drain: current bank keeps draining; no new release.
//  i_flush: next edge all FREE, sizes 0, queue empty; no o_done; o_irq unchanged; flush wins over commit.
//  Async reset mid-drain: immediate return to reset state; reader sees size 0.
//  Arithmetic: all counts unsigned 32-bit; size compare is unsigned; no wrap handling needed.
// CONFIGURATION
//  `WB_MEM_SCHED_TIMEOUT_EN defined: watchdog counter runs while a bank is DRAINING.
//    Counter restarts whenever i_mem_N_count changes.
//    At TIMEOUT_CYCLES: bank forced FREE, size 0, o_timeout=1 (sticky until rst/i_flush), no o_done.
//  Not defined: no counter logic; o_timeout tied 0.
// STRUCTURE
//  Shared package wb_mem_sched_pkg: bank state encoding (FREE=2'd0, LOADED=2'd1, DRAINING=2'd2); BANK_SIZE_MAX default.
//  Sub-module wb_mem_sched_bank: one slot (state, base, size regs, new_data pulse, drain detect), instantiated twice.
//  Top level holds the order queue, release arbiter, irq and watchdog.
// TESTING
//  1. Commit (0x0,16) with enable=1 -> bank0 release 1 cycle later, size0=16, new_data0 pulse.
//     Count0=0 with read_finished -> o_done, done_bank=0, irq=1.
//  2. Commit A(0x0,8) then B(0x200000,4) -> B stays at size 0 until A done; B released 1 cycle after A frees.
//  3. Third commit while both busy -> o_commit_err pulse, state unchanged. Size 0x00200001 -> o_commit_err.
//  4. read_finished with count0=3 -> no done. Commit size 0 -> o_done next cycle, no new_data.
//  5. i_flush mid-drain -> sizes 0, busy=0, irq held. i_irq_clear and o_done same cycle -> irq=0.
//  6. TIMEOUT_EN, TIMEOUT_CYCLES=8, count frozen at 5 -> bank FREE after 8 cycles, o_timeout=1, no o_done.

Source files
------------

// File: rtl/wb_mem_sched_pkg.sv
// Shared types and defaults for the two-bank memory scheduler.
package wb_mem_sched_pkg;

   localparam int unsigned DATA_W = 32;
   localparam logic [DATA_W-1:0] BANK_SIZE_MAX_DEFAULT = 32'h0020_0000;

   typedef enum logic [1:0] {
      BANK_FREE     = 2'd0,
      BANK_LOADED   = 2'd1,
      BANK_DRAINING = 2'd2
   } bank_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] base;
      logic [DATA_W-1:0] size;
   } commit_t;

endpackage

// File: rtl/wb_mem_sched_bank.sv
// One bank slot: FREE -> LOADED -> DRAINING -> FREE. Holds base/size and
// presents the size to the reader only while the bank is draining.
module wb_mem_sched_bank
   import wb_mem_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  commit_t           load_data,
   input  logic              release_req,
   input  logic              force_free,
   input  logic              read_finished,
   input  logic [DATA_W-1:0] count,
   output bank_state_e       state,
   output bank_state_e       state_nxt_c,
   output logic              drain_c,
   output logic [DATA_W-1:0] base,
   output logic [DATA_W-1:0] size,
   output logic              new_data
);

   logic [DATA_W-1:0] size_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BANK_FREE;
         base     <= '0;
         size_q   <= '0;
         size     <= '0;
         new_data <= 1'b0;
      end else begin
         state    <= state_nxt_c;
         size     <= (state_nxt_c == BANK_DRAINING) ? size_q : '0;
         new_data <= (state == BANK_LOADED) && (state_nxt_c == BANK_DRAINING);
         if (load && (state == BANK_FREE)) begin
            base   <= load_data.base;
            size_q <= load_data.size;
         end
      end
   end

   // Drain is seen only when the reader reports a finished block with nothing left.
   always_comb begin
      state_nxt_c = state;
      drain_c     = (state == BANK_DRAINING) && read_finished && (count == '0);
      if (flush) begin
         state_nxt_c = BANK_FREE;
      end else begin
         unique case (state)
            BANK_FREE:     if (load)                  state_nxt_c = BANK_LOADED;
            BANK_LOADED:   if (release_req)           state_nxt_c = BANK_DRAINING;
            BANK_DRAINING: if (drain_c || force_free) state_nxt_c = BANK_FREE;
            default:                                  state_nxt_c = BANK_FREE;
         endcase
      end
   end

endmodule

// File: rtl/wb_mem_bank_scheduler.sv
// Feeds two host-committed banks to the memory reader in commit order.
// Optional drain watchdog enabled by defining WB_MEM_SCHED_TIMEOUT_EN.
module wb_mem_bank_scheduler
   import wb_mem_sched_pkg::*;
#(
   parameter logic [DATA_W-1:0] BANK_SIZE_MAX = BANK_SIZE_MAX_DEFAULT
`ifdef WB_MEM_SCHED_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_flush,
   input  logic              i_commit,
   input  logic [DATA_W-1:0] i_commit_base,
   input  logic [DATA_W-1:0] i_commit_size,
   output logic              o_commit_ready,
   output logic              o_commit_err,
   output logic [DATA_W-1:0] o_mem_0_base,
   output logic [DATA_W-1:0] o_mem_0_size,
   output logic              o_mem_0_new_data,
   input  logic [DATA_W-1:0] i_mem_0_count,
   output logic [DATA_W-1:0] o_mem_1_base,
   output logic [DATA_W-1:0] o_mem_1_size,
   output logic              o_mem_1_new_data,
   input  logic [DATA_W-1:0] i_mem_1_count,
   input  logic              i_read_finished,
   output logic              o_done,
   output logic              o_done_bank,
   output logic              o_irq,
   input  logic              i_irq_clear,
   output logic              o_busy,
   output logic              o_timeout
);

   bank_state_e st0, st1, st0_nxt, st1_nxt;
   logic        drain0_c, drain1_c, ffree0_c, ffree1_c;
   logic        any_free_c, size_ok_c, accept_c, err_c, sel_c, push_c, zero_c;
   logic        draining_c, head_loaded_c, rel_c, done_c, done_bank_c;
   logic [1:0]  q_q, q_nxt, q_cnt, q_cnt_nxt;
   commit_t     commit_c;

   assign commit_c = '{base: i_commit_base, size: i_commit_size};

   always_comb begin
      any_free_c    = (st0 == BANK_FREE) || (st1 == BANK_FREE);
      size_ok_c     = (i_commit_size <= BANK_SIZE_MAX);
      accept_c      = i_commit && !i_flush && any_free_c && size_ok_c;
      err_c         = i_commit && !i_flush && !(any_free_c && size_ok_c);
      sel_c         = (st0 != BANK_FREE);
      push_c        = accept_c && (i_commit_size != '0);
      zero_c        = accept_c && (i_commit_size == '0);
      draining_c    = (st0 == BANK_DRAINING) || (st1 == BANK_DRAINING);
      head_loaded_c = q_q[0] ? (st1 == BANK_LOADED) : (st0 == BANK_LOADED);
      rel_c         = i_enable && !i_flush && (q_cnt != 2'd0) && !draining_c && head_loaded_c;
      done_c        = !i_flush && (drain0_c || drain1_c || zero_c);
      done_bank_c   = drain1_c ? 1'b1 : (drain0_c ? 1'b0 : (zero_c ? sel_c : o_done_bank));
   end

   // Commit-order queue: head pops on release, accepted non-empty commits push.
   always_comb begin
      q_nxt     = q_q;
      q_cnt_nxt = q_cnt;
      if (i_flush) begin
         q_cnt_nxt = 2'd0;
      end else begin
         if (rel_c) begin
            q_nxt[0]  = q_q[1];
            q_cnt_nxt = q_cnt - 2'd1;
         end
         if (push_c) begin
            q_nxt[q_cnt_nxt[0]] = sel_c;
            q_cnt_nxt           = q_cnt_nxt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q            <= '0;
         q_cnt          <= '0;
         o_commit_ready <= 1'b1;
         o_commit_err   <= 1'b0;
         o_done         <= 1'b0;
         o_done_bank    <= 1'b0;
         o_irq          <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         q_q            <= q_nxt;
         q_cnt          <= q_cnt_nxt;
         o_commit_ready <= (st0_nxt == BANK_FREE) || (st1_nxt == BANK_FREE);
         o_commit_err   <= err_c;
         o_done         <= done_c;
         o_done_bank    <= done_bank_c;
         o_irq          <= i_irq_clear ? 1'b0 : (done_c ? 1'b1 : o_irq);
         o_busy         <= (st0_nxt != BANK_FREE) || (st1_nxt != BANK_FREE);
      end
   end

`ifdef WB_MEM_SCHED_TIMEOUT_EN
   logic [DATA_W-1:0] wd_cnt, wd_prev, wd_count_c;
   logic              wd_changed_c, wd_hit_c;

   // Watchdog restarts whenever the draining bank's remaining count moves.
   always_comb begin
      wd_count_c   = (st1 == BANK_DRAINING) ? i_mem_1_count : i_mem_0_count;
      wd_changed_c = (wd_count_c != wd_prev);
      wd_hit_c     = draining_c && !i_flush && !wd_changed_c &&
                     (wd_cnt == DATA_W'(TIMEOUT_CYCLES - 1));
      ffree0_c     = wd_hit_c && (st0 == BANK_DRAINING);
      ffree1_c     = wd_hit_c && (st1 == BANK_DRAINING);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt    <= '0;
         wd_prev   <= '0;
         o_timeout <= 1'b0;
      end else begin
         wd_prev   <= wd_count_c;
         wd_cnt    <= (!draining_c || wd_changed_c || wd_hit_c || i_flush) ? '0 : wd_cnt + DATA_W'(1);
         o_timeout <= i_flush ? 1'b0 : ((wd_hit_c && !drain0_c && !drain1_c) ? 1'b1 : o_timeout);
      end
   end
`else
   assign ffree0_c  = 1'b0;
   assign ffree1_c  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   wb_mem_sched_bank u_bank0 (
      .clk           (clk),
      .rst           (rst),
      .flush         (i_flush),
      .load          (push_c && !sel_c),
      .load_data     (commit_c),
      .release_req   (rel_c && !q_q[0]),
      .force_free    (ffree0_c),
      .read_finished (i_read_finished),
      .count         (i_mem_0_count),
      .state         (st0),
      .state_nxt_c   (st0_nxt),
      .drain_c       (drain0_c),
      .base          (o_mem_0_base),
      .size          (o_mem_0_size),
      .new_data      (o_mem_0_new_data)
   );

   wb_mem_sched_bank u_bank1 (
      .clk           (clk),
      .rst           (rst),
      .flush         (i_flush),
      .load          (push_c && sel_c),
      .load_data     (commit_c),
      .release_req   (rel_c && q_q[0]),
      .force_free    (ffree1_c),
      .read_finished (i_read_finished),
      .count         (i_mem_1_count),
      .state         (st1),
      .state_nxt_c   (st1_nxt),
      .drain_c       (drain1_c),
      .base          (o_mem_1_base),
      .size          (o_mem_1_size),
      .new_data      (o_mem_1_new_data)
   );

endmodule

// File: tb/tb_wb_mem_bank_scheduler.sv
// Bench for wb_mem_bank_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model of the bank rules.
module tb_wb_mem_bank_scheduler;

   localparam logic [31:0] MAX = 32'h0020_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        i_enable = 1'b0, i_flush = 1'b0, i_commit = 1'b0;
   logic [31:0] i_commit_base = '0, i_commit_size = '0;
   logic        o_commit_ready, o_commit_err;
   logic [31:0] o_mem_0_base, o_mem_0_size, o_mem_1_base, o_mem_1_size;
   logic        o_mem_0_new_data, o_mem_1_new_data;
   logic [31:0] i_mem_0_count = '0, i_mem_1_count = '0;
   logic        i_read_finished = 1'b0, i_irq_clear = 1'b0;
   logic        o_done, o_done_bank, o_irq, o_busy, o_timeout;

   int checks = 0;
   int errors = 0;

   // reference model state (0 free, 1 loaded, 2 draining)
   int          m_st[2];
   logic [31:0] m_size[2], m_base[2];
   int          m_q[$];
   logic        m_irq, m_db, e_done, e_err;
   logic        e_nd[2];

   wb_mem_bank_scheduler #(
      .BANK_SIZE_MAX (MAX)
`ifdef WB_MEM_SCHED_TIMEOUT_EN
      , .TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clk (clk), .rst (rst), .i_enable (i_enable), .i_flush (i_flush),
      .i_commit (i_commit), .i_commit_base (i_commit_base), .i_commit_size (i_commit_size),
      .o_commit_ready (o_commit_ready), .o_commit_err (o_commit_err),
      .o_mem_0_base (o_mem_0_base), .o_mem_0_size (o_mem_0_size),
      .o_mem_0_new_data (o_mem_0_new_data), .i_mem_0_count (i_mem_0_count),
      .o_mem_1_base (o_mem_1_base), .o_mem_1_size (o_mem_1_size),
      .o_mem_1_new_data (o_mem_1_new_data), .i_mem_1_count (i_mem_1_count),
      .i_read_finished (i_read_finished), .o_done (o_done), .o_done_bank (o_done_bank),
      .o_irq (o_irq), .i_irq_clear (i_irq_clear), .o_busy (o_busy), .o_timeout (o_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      i_commit = 1'b0; i_flush = 1'b0; i_irq_clear = 1'b0; i_read_finished = 1'b0;
   endtask

   task automatic commit(input logic [31:0] b, input logic [31:0] s);
      i_commit = 1'b1; i_commit_base = b; i_commit_size = s;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({o_commit_ready, o_commit_err, o_mem_0_new_data, o_mem_1_new_data, o_done,
           o_done_bank, o_irq, o_busy, o_timeout} !== 9'b1_0000_0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 100000000", {o_commit_ready, o_commit_err,
                  o_mem_0_new_data, o_mem_1_new_data, o_done, o_done_bank, o_irq, o_busy, o_timeout});
      end
      checks++;
      if ({o_mem_0_base, o_mem_0_size, o_mem_1_base, o_mem_1_size} !== 128'h0) begin
         errors++;
         $display("FAIL reset_buses got %h exp 0", {o_mem_0_base, o_mem_0_size, o_mem_1_base, o_mem_1_size});
      end
   endtask

   task automatic test_single();
      logic [31:0] b, s;
      b = $urandom; s = 32'(1 + $urandom % 100);
      i_enable = 1'b1;
      commit(b, s); tick();
      checks++;
      if (o_mem_0_base !== b || o_mem_0_size !== 0 || o_busy !== 1'b1) begin
         errors++; $display("FAIL single_load base %h size %h busy %b exp %h 0 1", o_mem_0_base, o_mem_0_size, o_busy, b);
      end
      tick();
      checks++;
      if (o_mem_0_size !== s || o_mem_0_new_data !== 1'b1) begin
         errors++; $display("FAIL single_release size %h nd %b exp %h 1", o_mem_0_size, o_mem_0_new_data, s);
      end
      tick();
      checks++;
      if (o_mem_0_new_data !== 1'b0 || o_mem_0_size !== s) begin
         errors++; $display("FAIL single_nd_pulse nd %b size %h exp 0 %h", o_mem_0_new_data, o_mem_0_size, s);
      end
      i_mem_0_count = 32'd3; i_read_finished = 1'b1; tick();
      checks++;
      if (o_done !== 1'b0 || o_mem_0_size !== s) begin
         errors++; $display("FAIL count_nonzero done %b size %h exp 0 %h", o_done, o_mem_0_size, s);
      end
      i_mem_0_count = 32'd0; i_read_finished = 1'b1; tick();
      checks++;
      if ({o_done, o_done_bank, o_irq, o_busy} !== 4'b1010 || o_mem_0_size !== 0) begin
         errors++; $display("FAIL single_drain flags %b size %h exp 1010 0", {o_done, o_done_bank, o_irq, o_busy}, o_mem_0_size);
      end
      i_irq_clear = 1'b1; tick();
      checks++;
      if (o_irq !== 1'b0 || o_done !== 1'b0) begin
         errors++; $display("FAIL irq_clear irq %b done %b exp 0 0", o_irq, o_done);
      end
   endtask

   task automatic test_order();
      commit(32'h0, 32'd8); tick();
      commit(MAX, 32'd4); tick();
      checks++;
      if (o_mem_0_size !== 32'd8 || o_mem_0_new_data !== 1'b1 || o_mem_1_size !== 0 ||
          o_mem_1_base !== MAX || o_commit_ready !== 1'b0) begin
         errors++; $display("FAIL order_a size0 %h nd0 %b size1 %h base1 %h rdy %b", o_mem_0_size,
                            o_mem_0_new_data, o_mem_1_size, o_mem_1_base, o_commit_ready);
      end
      i_mem_0_count = 32'd0; i_read_finished = 1'b1; tick();
      checks++;
      if ({o_done, o_done_bank, o_mem_1_new_data} !== 3'b100 || o_mem_0_size !== 0 || o_mem_1_size !== 0) begin
         errors++; $display("FAIL order_a_done flags %b size0 %h size1 %h exp 100 0 0",
                            {o_done, o_done_bank, o_mem_1_new_data}, o_mem_0_size, o_mem_1_size);
      end
      tick();
      checks++;
      if (o_mem_1_size !== 32'd4 || o_mem_1_new_data !== 1'b1) begin
         errors++; $display("FAIL order_b_release size1 %h nd1 %b exp 4 1", o_mem_1_size, o_mem_1_new_data);
      end
      i_mem_1_count = 32'd0; i_read_finished = 1'b1; tick();
      checks++;
      if ({o_done, o_done_bank} !== 2'b11) begin
         errors++; $display("FAIL order_b_done got %b exp 11", {o_done, o_done_bank});
      end
      i_irq_clear = 1'b1; tick();
   endtask

   task automatic test_errors();
      i_enable = 1'b0;
      commit(32'h10, 32'd5); tick();
      commit(32'h20, MAX + 32'd1); tick();
      checks++;
      if (o_commit_err !== 1'b1 || o_commit_ready !== 1'b1) begin
         errors++; $display("FAIL err_oversize err %b rdy %b exp 1 1", o_commit_err, o_commit_ready);
      end
      commit(32'h30, MAX); tick();
      checks++;
      if (o_commit_err !== 1'b0 || o_commit_ready !== 1'b0 || o_mem_1_base !== 32'h30) begin
         errors++; $display("FAIL max_size_ok err %b rdy %b base1 %h exp 0 0 30", o_commit_err, o_commit_ready, o_mem_1_base);
      end
      commit(32'h40, 32'd3); tick();
      checks++;
      if (o_commit_err !== 1'b1 || o_mem_0_base !== 32'h10 || o_mem_1_base !== 32'h30 ||
          o_mem_0_size !== 0 || o_mem_1_size !== 0) begin
         errors++; $display("FAIL err_full err %b base0 %h base1 %h exp 1 10 30", o_commit_err, o_mem_0_base, o_mem_1_base);
      end
      tick();
      checks++;
      if (o_commit_err !== 1'b0) begin
         errors++; $display("FAIL err_pulse got %b exp 0", o_commit_err);
      end
      i_enable = 1'b1; tick();
      checks++;
      if (o_mem_0_size !== 32'd5 || o_mem_0_new_data !== 1'b1 || o_mem_1_size !== 0) begin
         errors++; $display("FAIL enable_release size0 %h nd0 %b size1 %h exp 5 1 0", o_mem_0_size, o_mem_0_new_data, o_mem_1_size);
      end
      i_mem_0_count = 32'd0; i_read_finished = 1'b1; tick();
      tick();
      checks++;
      if (o_mem_1_size !== MAX) begin
         errors++; $display("FAIL max_release size1 %h exp %h", o_mem_1_size, MAX);
      end
      i_mem_1_count = 32'd0; i_read_finished = 1'b1; tick();
      i_irq_clear = 1'b1; tick();
   endtask

   task automatic test_zero();
      commit(32'h50, 32'd0); tick();
      checks++;
      if ({o_done, o_done_bank, o_mem_0_new_data, o_busy, o_irq} !== 5'b10001) begin
         errors++; $display("FAIL zero_commit got %b exp 10001", {o_done, o_done_bank, o_mem_0_new_data, o_busy, o_irq});
      end
      tick();
      checks++;
      if (o_done !== 1'b0 || o_mem_0_new_data !== 1'b0 || o_mem_0_size !== 0) begin
         errors++; $display("FAIL zero_no_release done %b nd0 %b size0 %h exp 0 0 0", o_done, o_mem_0_new_data, o_mem_0_size);
      end
   endtask

   task automatic test_flush_irq();
      commit(32'h60, 32'd7); tick(); tick();
      i_flush = 1'b1; tick();
      checks++;
      if (o_mem_0_size !== 0 || {o_busy, o_irq, o_done, o_commit_ready} !== 4'b0101) begin
         errors++; $display("FAIL flush size0 %h flags %b exp 0 0101", o_mem_0_size, {o_busy, o_irq, o_done, o_commit_ready});
      end
      i_mem_0_count = 32'd0; i_read_finished = 1'b1; tick();
      checks++;
      if (o_done !== 1'b0) begin
         errors++; $display("FAIL flush_no_done got %b exp 0", o_done);
      end
      commit(32'h0, 32'd0); i_irq_clear = 1'b1; tick();
      checks++;
      if (o_done !== 1'b1 || o_irq !== 1'b0) begin
         errors++; $display("FAIL clear_wins done %b irq %b exp 1 0", o_done, o_irq);
      end
   endtask

   task automatic test_async_reset();
      commit(32'h40, 32'd9); tick(); tick();
      checks++;
      if (o_mem_0_size !== 32'd9) begin
         errors++; $display("FAIL pre_reset size0 %h exp 9", o_mem_0_size);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_mem_0_size !== 0 || o_mem_0_base !== 0 || o_busy !== 1'b0 || o_commit_ready !== 1'b1) begin
         errors++; $display("FAIL async_reset size0 %h base0 %h busy %b rdy %b", o_mem_0_size, o_mem_0_base, o_busy, o_commit_ready);
      end
      #2 rst = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef WB_MEM_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      logic saw_done;
      saw_done = 1'b0;
      i_enable = 1'b1; i_mem_0_count = 32'd5;
      commit(32'h70, 32'd6); tick(); tick();
      repeat (7) begin tick(); saw_done |= o_done; end
      checks++;
      if (o_mem_0_size !== 32'd6 || o_timeout !== 1'b0) begin
         errors++; $display("FAIL timeout_early size0 %h to %b exp 6 0", o_mem_0_size, o_timeout);
      end
      tick(); saw_done |= o_done;
      checks++;
      if (o_mem_0_size !== 0 || o_timeout !== 1'b1 || o_busy !== 1'b0 || saw_done !== 1'b0) begin
         errors++; $display("FAIL timeout_fire size0 %h to %b busy %b done %b", o_mem_0_size, o_timeout, o_busy, saw_done);
      end
      i_flush = 1'b1; tick();
      checks++;
      if (o_timeout !== 1'b0) begin
         errors++; $display("FAIL timeout_flush got %b exp 0", o_timeout);
      end
   endtask
`endif

   // Advance the reference model by one clock using the inputs now applied.
   task automatic model_step();
      int  rel, drn;
      bit  zero, sel, any_free;
      e_nd[0] = 1'b0; e_nd[1] = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (i_flush) begin
         m_st[0] = 0; m_st[1] = 0; m_q.delete();
      end else begin
         rel = -1; drn = -1; zero = 1'b0;
         any_free = (m_st[0] == 0) || (m_st[1] == 0);
         sel = (m_st[0] != 0);
         if (i_enable && m_st[0] != 2 && m_st[1] != 2 && m_q.size() > 0) rel = m_q[0];
         if (m_st[0] == 2 && i_read_finished && i_mem_0_count == 0) drn = 0;
         if (m_st[1] == 2 && i_read_finished && i_mem_1_count == 0) drn = 1;
         if (i_commit) begin
            if (!any_free || i_commit_size > MAX) e_err = 1'b1;
            else if (i_commit_size == 0) zero = 1'b1;
            else begin
               m_st[sel] = 1; m_base[sel] = i_commit_base; m_size[sel] = i_commit_size;
               m_q.push_back(int'(sel));
            end
         end
         if (rel >= 0) begin m_st[rel] = 2; e_nd[rel] = 1'b1; void'(m_q.pop_front()); end
         if (drn >= 0) m_st[drn] = 0;
         e_done = (drn >= 0) || zero;
         if (drn >= 0) m_db = drn[0];
         else if (zero) m_db = sel;
      end
      m_irq = i_irq_clear ? 1'b0 : (e_done ? 1'b1 : m_irq);
   endtask

   task automatic test_random();
      logic [135:0] exp_v, act_v;
      int r;
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      m_st[0] = 0; m_st[1] = 0; m_q.delete(); m_base[0] = '0; m_base[1] = '0;
      m_size[0] = '0; m_size[1] = '0; m_irq = 1'b0; m_db = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         i_enable        = ($urandom % 4) != 0;
         i_flush         = ($urandom % 40) == 0;
         i_irq_clear     = ($urandom % 5) == 0;
         i_read_finished = $urandom % 2;
         i_mem_0_count   = (i_mem_0_count + 32'd1 + 32'($urandom % 2)) % 32'd3;
         i_mem_1_count   = (i_mem_1_count + 32'd1 + 32'($urandom % 2)) % 32'd3;
         i_commit        = ($urandom % 3) == 0;
         i_commit_base   = $urandom;
         r = $urandom % 8;
         i_commit_size   = (r == 0) ? 32'd0 : (r == 1) ? MAX : (r == 2) ? MAX + 32'd1 : 32'(1 + $urandom % 1000);
         model_step();
         tick();
         exp_v = {m_base[0], m_base[1], (m_st[0] == 2) ? m_size[0] : 32'h0, (m_st[1] == 2) ? m_size[1] : 32'h0,
                  e_nd[0], e_nd[1], e_done, m_db, m_irq, e_err,
                  (m_st[0] == 0) || (m_st[1] == 0), (m_st[0] != 0) || (m_st[1] != 0)};
         act_v = {o_mem_0_base, o_mem_1_base, o_mem_0_size, o_mem_1_size, o_mem_0_new_data, o_mem_1_new_data,
                  o_done, o_done_bank, o_irq, o_commit_err, o_commit_ready, o_busy};
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL random cycle %0d got %h exp %h", cyc, act_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_errors();
      test_zero();
      test_flush_irq();
      test_async_reset();
`ifdef WB_MEM_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
